// File: rtl/wakeup_issue_queue_if.sv
// Router/FU-facing bundle for the wake-up issue queue: enqueue, wake broadcast,
// PRF read port and issue handshake. The queue itself uses the slave modport.
interface wakeup_issue_queue_if #(
  parameter int DEPTH        = 8,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int INST_ID_BITS = 6,
  parameter int WAKE_PORTS   = 4
);
  logic                                             flush;
  logic                                             enq_valid;
  logic                                             enq_ready;
  logic [INST_ID_BITS-1:0]                          enq_inst_id;
  logic [31:0]                                      enq_raw_instr;
  logic [63:0]                                      enq_pc;
  logic [MAX_OPERANDS-1:0]                          enq_src_valid;
  logic [MAX_OPERANDS-1:0]                          enq_src_ready;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            enq_src_prn;
  logic [MAX_OPERANDS-1:0]                          enq_dst_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            enq_dst_prn;
  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]          wake_valid;
  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wake_prn;
  logic [MAX_OPERANDS-1:0]                          prf_read_enable;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            prf_read_prn;
  logic [MAX_OPERANDS-1:0][63:0]                    prf_op;
  logic                                             iss_valid;
  logic                                             iss_ready;
  logic [INST_ID_BITS-1:0]                          iss_inst_id;
  logic [31:0]                                      iss_raw_instr;
  logic [63:0]                                      iss_pc;
  logic [MAX_OPERANDS-1:0][63:0]                    iss_op;
  logic [MAX_OPERANDS-1:0]                          iss_dst_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]            iss_dst_prn;
  logic [$clog2(DEPTH+1)-1:0]                       occupancy;

  modport master (
    output flush, enq_valid, enq_inst_id, enq_raw_instr, enq_pc, enq_src_valid,
           enq_src_ready, enq_src_prn, enq_dst_valid, enq_dst_prn, wake_valid,
           wake_prn, prf_op, iss_ready,
    input  enq_ready, prf_read_enable, prf_read_prn, iss_valid, iss_inst_id,
           iss_raw_instr, iss_pc, iss_op, iss_dst_valid, iss_dst_prn, occupancy
  );

  modport slave (
    input  flush, enq_valid, enq_inst_id, enq_raw_instr, enq_pc, enq_src_valid,
           enq_src_ready, enq_src_prn, enq_dst_valid, enq_dst_prn, wake_valid,
           wake_prn, prf_op, iss_ready,
    output enq_ready, prf_read_enable, prf_read_prn, iss_valid, iss_inst_id,
           iss_raw_instr, iss_pc, iss_op, iss_dst_valid, iss_dst_prn, occupancy
  );
endinterface

// File: rtl/wakeup_issue_queue.sv
// Collapsing oldest-first issue queue with source wake-up and a select/PRF-read pipe; select to iss_valid is 2 cycles.
// Backpressure: iss_ready low holds the output stage, parks at most one read-stage entry, then blocks select; enq_ready drops when full or flushing.
module wakeup_issue_queue #(
  parameter int DEPTH        = 8,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int INST_ID_BITS = 6,
  parameter int WAKE_PORTS   = 4
) (
  input logic                clk,
  input logic                rst,
  wakeup_issue_queue_if.slave q_if
);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int IDX_BITS = $clog2(DEPTH);

  typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn_vec_t;
  typedef logic [MAX_OPERANDS-1:0][63:0]         op_vec_t;

  typedef struct packed {
    logic [INST_ID_BITS-1:0] inst_id;
    logic [31:0]             raw_instr;
    logic [63:0]             pc;
    logic [MAX_OPERANDS-1:0] src_valid;
    logic [MAX_OPERANDS-1:0] src_ready;
    prn_vec_t                src_prn;
    logic [MAX_OPERANDS-1:0] dst_valid;
    prn_vec_t                dst_prn;
  } entry_t;

  typedef struct packed {
    logic [INST_ID_BITS-1:0] inst_id;
    logic [31:0]             raw_instr;
    logic [63:0]             pc;
    logic [MAX_OPERANDS-1:0] src_valid;
    logic [MAX_OPERANDS-1:0] dst_valid;
    prn_vec_t                dst_prn;
  } meta_t;

  entry_t                q [DEPTH];
  entry_t                q_up [DEPTH];
  entry_t                q_nxt [DEPTH];
  logic [CNT_BITS-1:0]   count;
  logic [CNT_BITS-1:0]   count_left;

  logic                  rd_vld, rd_pend, out_vld;
  meta_t                 rd_meta, out_meta;
  op_vec_t               rd_op, out_op, cap_op;

  logic                  sel_found, advance, issue, enq_fire, out_take;
  logic [IDX_BITS-1:0]   sel_idx;
  entry_t                sel_ent, enq_ent;

  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]                wake_vld;
  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  wake_prn;

  assign wake_vld = q_if.wake_valid;
  assign wake_prn = q_if.wake_prn;

  function automatic logic wake_hit(
    input logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]               vld,
    input logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] prns,
    input logic [PRN_BITS-1:0]                                   prn
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      for (int o = 0; o < MAX_OPERANDS; o++) begin
        if (vld[p][o] && (prns[p][o] == prn)) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Eligibility uses only registered ready bits, so a wake is visible to select one cycle later.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_BITS'(i) < count) && (&(~q[i].src_valid | q[i].src_ready))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_BITS'(i);
      end
    end
  end

  assign advance  = !rd_vld || !out_vld || q_if.iss_ready;
  assign issue    = sel_found && advance && !q_if.flush;
  assign sel_ent  = q[sel_idx];
  assign q_if.enq_ready = (count < CNT_BITS'(DEPTH)) && !q_if.flush;
  assign enq_fire = q_if.enq_valid && q_if.enq_ready;
  assign out_take = rd_vld && (!out_vld || q_if.iss_ready);

  assign q_if.prf_read_enable = issue ? sel_ent.src_valid : '0;
  assign q_if.prf_read_prn    = sel_ent.src_prn;

  always_comb begin
    enq_ent.inst_id   = q_if.enq_inst_id;
    enq_ent.raw_instr = q_if.enq_raw_instr;
    enq_ent.pc        = q_if.enq_pc;
    enq_ent.src_valid = q_if.enq_src_valid;
    enq_ent.src_ready = q_if.enq_src_ready;
    enq_ent.src_prn   = q_if.enq_src_prn;
    enq_ent.dst_valid = q_if.enq_dst_valid;
    enq_ent.dst_prn   = q_if.enq_dst_prn;
    for (int o = 0; o < MAX_OPERANDS; o++) begin
      if (wake_hit(wake_vld, wake_prn, q_if.enq_src_prn[o])) enq_ent.src_ready[o] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) q_up[i] = q[i + 1];
    q_up[DEPTH-1] = q[DEPTH-1];
  end

  // Collapse above the issued slot, fold in this cycle's wakes, then append at the new tail.
  always_comb begin
    entry_t nxt;
    count_left = count - CNT_BITS'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      nxt = (issue && (IDX_BITS'(i) >= sel_idx)) ? q_up[i] : q[i];
      for (int o = 0; o < MAX_OPERANDS; o++) begin
        if (wake_hit(wake_vld, wake_prn, nxt.src_prn[o])) nxt.src_ready[o] = 1'b1;
      end
      q_nxt[i] = nxt;
    end
    if (enq_fire) q_nxt[IDX_BITS'(count_left)] = enq_ent;
  end

  // PRF data is live only in the cycle after select; afterwards the parked copy is used.
  always_comb begin
    for (int o = 0; o < MAX_OPERANDS; o++) begin
      cap_op[o] = '0;
      if (rd_meta.src_valid[o]) cap_op[o] = rd_pend ? q_if.prf_op[o] : rd_op[o];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '{default: '0};
      count    <= '0;
      rd_vld   <= 1'b0;
      rd_pend  <= 1'b0;
      rd_meta  <= '0;
      rd_op    <= '0;
      out_vld  <= 1'b0;
      out_meta <= '0;
      out_op   <= '0;
    end else begin
      q     <= q_nxt;
      count <= q_if.flush ? '0 : count_left + CNT_BITS'(enq_fire);
      if (q_if.flush) begin
        rd_vld  <= 1'b0;
        rd_pend <= 1'b0;
        out_vld <= 1'b0;
      end else begin
        if (issue) begin
          rd_vld  <= 1'b1;
          rd_pend <= 1'b1;
          rd_meta <= '{inst_id: sel_ent.inst_id, raw_instr: sel_ent.raw_instr, pc: sel_ent.pc,
                       src_valid: sel_ent.src_valid, dst_valid: sel_ent.dst_valid,
                       dst_prn: sel_ent.dst_prn};
        end else if (out_take) begin
          rd_vld  <= 1'b0;
          rd_pend <= 1'b0;
        end else if (rd_pend) begin
          rd_op   <= q_if.prf_op;
          rd_pend <= 1'b0;
        end
        if (out_take) begin
          out_vld  <= 1'b1;
          out_meta <= rd_meta;
          out_op   <= cap_op;
        end else if (q_if.iss_ready) begin
          out_vld <= 1'b0;
        end
      end
    end
  end

  assign q_if.iss_valid     = out_vld;
  assign q_if.iss_inst_id   = out_meta.inst_id;
  assign q_if.iss_raw_instr = out_meta.raw_instr;
  assign q_if.iss_pc        = out_meta.pc;
  assign q_if.iss_op        = out_op;
  assign q_if.iss_dst_valid = out_meta.dst_valid;
  assign q_if.iss_dst_prn   = out_meta.dst_prn;
  assign q_if.occupancy     = count;
endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Randomised and directed bench for wakeup_issue_queue against a queue-level reference model.
module tb_wakeup_issue_queue;
  localparam int DEPTH = 8;
  localparam int M     = 3;
  localparam int P     = 6;
  localparam int ID    = 6;
  localparam int W     = 4;

  typedef struct packed {
    logic [ID-1:0]       id;
    logic [31:0]         raw;
    logic [63:0]         pc;
    logic [M-1:0]        sv;
    logic [M-1:0]        srdy;
    logic [M-1:0]        dv;
    logic [M-1:0][P-1:0] sprn;
    logic [M-1:0][P-1:0] dprn;
  } ment_t;

  typedef struct {
    ment_t e;
    int    sel;
  } pitem_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wakeup_issue_queue_if #(.DEPTH(DEPTH), .MAX_OPERANDS(M), .PRN_BITS(P),
                          .INST_ID_BITS(ID), .WAKE_PORTS(W)) q_if ();

  wakeup_issue_queue #(.DEPTH(DEPTH), .MAX_OPERANDS(M), .PRN_BITS(P),
                       .INST_ID_BITS(ID), .WAKE_PORTS(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (q_if)
  );

  ment_t  mq[$];
  pitem_t pipe[$];
  logic [63:0] prf_mem [64];

  ment_t                       d_enq;
  logic                        d_enq_valid;
  logic [W-1:0][M-1:0]         d_wake_valid;
  logic [W-1:0][M-1:0][P-1:0]  d_wake_prn;
  logic                        d_iss_ready;
  logic                        d_flush;
  logic [M-1:0]                prev_en;
  logic [M-1:0][P-1:0]         prev_prn;
  logic [ID-1:0]               id_ctr;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic woken(input logic [P-1:0] prn);
    for (int p = 0; p < W; p++)
      for (int o = 0; o < M; o++)
        if (d_wake_valid[p][o] && d_wake_prn[p][o] == prn) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_drive();
    d_enq        = '0;
    d_enq_valid  = 1'b0;
    d_wake_valid = '0;
    d_wake_prn   = '0;
    d_iss_ready  = 1'b1;
    d_flush      = 1'b0;
  endtask

  task automatic set_enq(input logic [ID-1:0] id, input logic [M-1:0] sv,
                         input logic [M-1:0] srdy, input logic [M-1:0][P-1:0] prn);
    d_enq_valid = 1'b1;
    d_enq.id    = id;
    d_enq.raw   = $urandom();
    d_enq.pc    = {$urandom(), $urandom()};
    d_enq.sv    = sv;
    d_enq.srdy  = srdy;
    d_enq.sprn  = prn;
    d_enq.dv    = 3'b101;
    d_enq.dprn  = {6'd17, 6'd0, P'(id)};
  endtask

  task automatic rand_drive();
    d_enq_valid = ($urandom_range(0, 1) == 1);
    d_enq.id    = id_ctr;
    id_ctr      = id_ctr + 1'b1;
    d_enq.raw   = $urandom();
    d_enq.pc    = {$urandom(), $urandom()};
    for (int o = 0; o < M; o++) begin
      d_enq.sv[o]   = ($urandom_range(0, 3) != 0);
      d_enq.srdy[o] = ($urandom_range(0, 2) == 0);
      d_enq.sprn[o] = P'($urandom_range(0, 15));
      d_enq.dv[o]   = ($urandom_range(0, 1) == 1);
      d_enq.dprn[o] = P'($urandom_range(0, 63));
    end
    for (int p = 0; p < W; p++)
      for (int o = 0; o < M; o++) begin
        d_wake_valid[p][o] = ($urandom_range(0, 7) == 0);
        d_wake_prn[p][o]   = P'($urandom_range(0, 15));
      end
    d_iss_ready = ($urandom_range(0, 3) != 0);
    d_flush     = ($urandom_range(0, 99) == 0);
  endtask

  task automatic apply();
    q_if.flush         = d_flush;
    q_if.enq_valid     = d_enq_valid;
    q_if.enq_inst_id   = d_enq.id;
    q_if.enq_raw_instr = d_enq.raw;
    q_if.enq_pc        = d_enq.pc;
    q_if.enq_src_valid = d_enq.sv;
    q_if.enq_src_ready = d_enq.srdy;
    q_if.enq_src_prn   = d_enq.sprn;
    q_if.enq_dst_valid = d_enq.dv;
    q_if.enq_dst_prn   = d_enq.dprn;
    q_if.wake_valid    = d_wake_valid;
    q_if.wake_prn      = d_wake_prn;
    q_if.iss_ready     = d_iss_ready;
    // PRF answers the previous cycle's requests; anything else on the bus is junk.
    for (int o = 0; o < M; o++)
      q_if.prf_op[o] = prev_en[o] ? prf_mem[prev_prn[o]] : {$urandom(), $urandom()};
  endtask

  // Reference: queue order is age order; the FU pipe is a 2-deep FIFO whose head shows 2 cycles after select.
  task automatic model_cycle();
    int k;
    logic adv, pres, exp_rdy;
    logic [M-1:0] exp_en;
    ment_t e;
    pitem_t it;
    chk("occupancy", 64'(q_if.occupancy), 64'(mq.size()));
    exp_rdy = (mq.size() < DEPTH) && !d_flush;
    chk("enq_ready", 64'(q_if.enq_ready), 64'(exp_rdy));
    adv = (pipe.size() < 2) || d_iss_ready;
    k = -1;
    if (!d_flush && adv)
      for (int i = 0; i < mq.size(); i++)
        if (k < 0 && ((~mq[i].sv | mq[i].srdy) == 3'b111)) k = i;
    exp_en = (k >= 0) ? mq[k].sv : '0;
    chk("prf_read_enable", 64'(q_if.prf_read_enable), 64'(exp_en));
    for (int o = 0; o < M; o++)
      if (exp_en[o]) chk("prf_read_prn", 64'(q_if.prf_read_prn[o]), 64'(mq[k].sprn[o]));
    pres = 1'b0;
    if (pipe.size() > 0) pres = (cyc - pipe[0].sel) >= 2;
    chk("iss_valid", 64'(q_if.iss_valid), 64'(pres));
    if (pres) begin
      e = pipe[0].e;
      chk("iss_inst_id", 64'(q_if.iss_inst_id), 64'(e.id));
      chk("iss_raw_instr", 64'(q_if.iss_raw_instr), 64'(e.raw));
      chk("iss_pc", q_if.iss_pc, e.pc);
      chk("iss_dst_valid", 64'(q_if.iss_dst_valid), 64'(e.dv));
      for (int o = 0; o < M; o++) begin
        chk("iss_op", q_if.iss_op[o], e.sv[o] ? prf_mem[e.sprn[o]] : 64'd0);
        chk("iss_dst_prn", 64'(q_if.iss_dst_prn[o]), 64'(e.dprn[o]));
      end
    end
    prev_en  = q_if.prf_read_enable;
    prev_prn = q_if.prf_read_prn;
    if (d_flush) begin
      mq.delete();
      pipe.delete();
    end else begin
      if (pres && d_iss_ready) void'(pipe.pop_front());
      if (k >= 0) begin
        it.e = mq[k];
        it.sel = cyc;
        pipe.push_back(it);
        mq.delete(k);
      end
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        for (int o = 0; o < M; o++) if (woken(e.sprn[o])) e.srdy[o] = 1'b1;
        mq[i] = e;
      end
      if (d_enq_valid && exp_rdy) begin
        e = d_enq;
        for (int o = 0; o < M; o++) if (woken(e.sprn[o])) e.srdy[o] = 1'b1;
        mq.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    apply();
    @(negedge clk);
    model_cycle();
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) prf_mem[i] = {$urandom(), $urandom()};
    prf_mem[5] = 64'h0000_0005_AAAA_0005;
    prf_mem[9] = 64'h0000_0009_BBBB_0009;
    id_ctr   = '0;
    prev_en  = '0;
    prev_prn = '0;
    clear_drive();
    apply();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset iss_valid", 64'(q_if.iss_valid), 64'd0);
    chk("reset occupancy", 64'(q_if.occupancy), 64'd0);
    chk("reset prf_read_enable", 64'(q_if.prf_read_enable), 64'd0);
    chk("reset iss_pc", q_if.iss_pc, 64'd0);
    chk("reset iss_op0", q_if.iss_op[0], 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step();

    // Ready at enqueue: reads in cycle 1, issue in cycle 3.
    set_enq(6'd1, 3'b011, 3'b011, {6'd0, 6'd9, 6'd5});
    step();
    clear_drive();
    step();
    chk("t1 prf_read_enable", 64'(q_if.prf_read_enable), 64'h3);
    chk("t1 prf_read_prn0", 64'(q_if.prf_read_prn[0]), 64'd5);
    chk("t1 prf_read_prn1", 64'(q_if.prf_read_prn[1]), 64'd9);
    step();
    chk("t1 iss_valid early", 64'(q_if.iss_valid), 64'd0);
    step();
    chk("t1 iss_valid", 64'(q_if.iss_valid), 64'd1);
    chk("t1 iss_op0", q_if.iss_op[0], 64'h0000_0005_AAAA_0005);
    chk("t1 iss_op1", q_if.iss_op[1], 64'h0000_0009_BBBB_0009);
    chk("t1 iss_op2", q_if.iss_op[2], 64'd0);
    repeat (2) step();

    // Wake order: younger ready B goes first, A reads the cycle after its wake.
    set_enq(6'd2, 3'b001, 3'b000, {6'd0, 6'd0, 6'd12});
    step();
    set_enq(6'd3, 3'b001, 3'b001, {6'd0, 6'd0, 6'd3});
    step();
    clear_drive();
    d_wake_valid[2][0] = 1'b1;
    d_wake_prn[2][0]   = 6'd12;
    step();
    chk("t2 B read prn", 64'(q_if.prf_read_prn[0]), 64'd3);
    clear_drive();
    step();
    chk("t2 A read enable", 64'(q_if.prf_read_enable), 64'h1);
    chk("t2 A read prn", 64'(q_if.prf_read_prn[0]), 64'd12);
    step();
    chk("t2 first issue", 64'(q_if.iss_inst_id), 64'd3);
    step();
    chk("t2 second issue", 64'(q_if.iss_inst_id), 64'd2);
    step();

    // Full queue, one wake frees a slot for a waiting enqueue.
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(ID'(8 + i), 3'b001, 3'b000, {6'd0, 6'd0, P'(32 + i)});
      step();
    end
    clear_drive();
    step();
    chk("t3 occupancy full", 64'(q_if.occupancy), 64'd8);
    chk("t3 enq_ready full", 64'(q_if.enq_ready), 64'd0);
    set_enq(6'd16, 3'b001, 3'b000, {6'd0, 6'd0, 6'd48});
    d_wake_valid[0][1] = 1'b1;
    d_wake_prn[0][1]   = 6'd35;
    step();
    d_wake_valid = '0;
    step();
    chk("t3 select woken", 64'(q_if.prf_read_prn[0]), 64'd35);
    chk("t3 enq_ready still full", 64'(q_if.enq_ready), 64'd0);
    step();
    chk("t3 occupancy freed", 64'(q_if.occupancy), 64'd7);
    chk("t3 enq_ready freed", 64'(q_if.enq_ready), 64'd1);
    clear_drive();
    step();
    chk("t3 occupancy refilled", 64'(q_if.occupancy), 64'd8);
    step();

    // Flush with a concurrent enqueue and wake.
    set_enq(6'd63, 3'b000, 3'b000, '0);
    d_flush = 1'b1;
    d_wake_valid[1][0] = 1'b1;
    d_wake_prn[1][0]   = 6'd40;
    step();
    chk("t4 enq_ready in flush", 64'(q_if.enq_ready), 64'd0);
    clear_drive();
    step();
    chk("t4 occupancy after flush", 64'(q_if.occupancy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t4 iss_valid after flush", 64'(q_if.iss_valid), 64'd0);
      step();
    end

    // Backpressure: output holds, one entry parks in read, then oldest-first drain.
    d_iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_enq(ID'(20 + i), 3'b111, 3'b111, {P'(i + 1), P'(i + 9), P'(i + 5)});
      step();
      if (i == 3) chk("t5 stall id", 64'(q_if.iss_inst_id), 64'd20);
    end
    d_enq_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5 stall iss_valid", 64'(q_if.iss_valid), 64'd1);
      chk("t5 stall id", 64'(q_if.iss_inst_id), 64'd20);
    end
    chk("t5 stall occupancy", 64'(q_if.occupancy), 64'd2);
    d_iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5 drain valid", 64'(q_if.iss_valid), 64'd1);
      chk("t5 drain id", 64'(q_if.iss_inst_id), 64'(20 + i));
    end
    repeat (2) step();

    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end
    clear_drive();
    d_flush = 1'b1;
    step();
    clear_drive();
    repeat (3) step();

    // Reset in the middle of operation.
    d_iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_enq(ID'(40 + i), 3'b011, 3'b011, {6'd0, 6'd9, 6'd5});
      step();
    end
    d_enq_valid = 1'b0;
    repeat (2) step();
    chk("t6 occupancy before reset", 64'(q_if.occupancy), 64'd3);
    chk("t6 iss_valid before reset", 64'(q_if.iss_valid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t6 reset iss_valid", 64'(q_if.iss_valid), 64'd0);
    chk("t6 reset occupancy", 64'(q_if.occupancy), 64'd0);
    chk("t6 reset prf_read_enable", 64'(q_if.prf_read_enable), 64'd0);
    mq.delete();
    pipe.delete();
    prev_en = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_drive();
    step();
    chk("t6 enq_ready after reset", 64'(q_if.enq_ready), 64'd1);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
